// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR fault monitor: per-channel state encoding,
// channel indices and the 2-of-3 majority function.
package tmr_pkg;

  typedef enum logic [1:0] {
    OK      = 2'b00,
    SUSPECT = 2'b01,
    FAULTY  = 2'b10
  } ch_state_e;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  function automatic logic maj3(input logic x, input logic y, input logic w);
    return (x & y) | (x & w) | (y & w);
  endfunction

endpackage

// File: rtl/tmr_channel_tracker.sv
// Per-channel health tracker: counts consecutive disagreements with the vote
// and latches the channel as faulty after THRESH of them.
module tmr_channel_tracker #(
  parameter int THRESH = 4,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic mis,
  input  logic clear,
  output logic faulty
);
  import tmr_pkg::*;

  localparam logic [CNT_W:0] THRESH_EXT = (CNT_W + 1)'(THRESH);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    if (clear) begin
      state_d = OK;
      cnt_d   = '0;
    end else if (en) begin
      case (state_q)
        OK: begin
          if (mis) begin
            cnt_d   = CNT_W'(1);
            state_d = (THRESH == 1) ? FAULTY : SUSPECT;
          end
        end
        SUSPECT: begin
          if (!mis) begin
            cnt_d   = '0;
            state_d = OK;
          end else if (cnt_inc == THRESH_EXT) begin
            state_d = FAULTY;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        FAULTY:  ;
        default: begin
          state_d = OK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign faulty = (state_q == FAULTY);

endmodule

// File: rtl/tmr_fault_monitor.sv
// Registered stage after majority_gate: re-votes around latched faulty channels,
// reports per-channel disagreement, loss of majority and gate miscomputation.
module tmr_fault_monitor #(
  parameter int THRESH = 4,
  parameter int CNT_W  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       z,
  input  logic       clear,
  output logic       vote,
  output logic       vote_valid,
  output logic [2:0] mismatch,
  output logic [2:0] fault,
  output logic       uncorrectable,
  output logic       gate_err
);
  import tmr_pkg::*;

  logic [2:0] ch, healthy, mis_next;
  logic [1:0] n_faulty, n_ones, n_zeros;
  logic       vote_next, unc_next;

  logic       vote_q, vote_d;
  logic       vote_valid_q, vote_valid_d;
  logic [2:0] mismatch_q, mismatch_d;
  logic       uncorrectable_q, uncorrectable_d;
  logic       gate_err_q, gate_err_d;

  always_comb begin
    ch          = '0;
    ch[CH_A]    = a;
    ch[CH_B]    = b;
    ch[CH_C]    = c;
    // A clearing sample is voted as if every channel were healthy.
    healthy     = clear ? 3'b111 : ~fault;
    n_faulty    = '0;
    n_ones      = '0;
    n_zeros     = '0;
    for (int i = 0; i < 3; i++) begin
      n_faulty += {1'b0, ~healthy[i]};
      n_ones   += {1'b0, ch[i] & healthy[i]};
      n_zeros  += {1'b0, ~ch[i] & healthy[i]};
    end

    vote_next = vote_q;
    unc_next  = 1'b0;
    case (n_faulty)
      2'd0: vote_next = z;
      2'd1: begin
        if (n_ones == 2'd2)       vote_next = 1'b1;
        else if (n_zeros == 2'd2) vote_next = 1'b0;
        else                      unc_next  = 1'b1;
      end
      2'd2:    vote_next = |(ch & healthy);
      default: unc_next  = 1'b1;
    endcase
    mis_next = healthy & (ch ^ {3{vote_next}}) & ~{3{unc_next}};

    vote_d          = valid ? vote_next : vote_q;
    vote_valid_d    = valid;
    mismatch_d      = valid ? mis_next : mismatch_q;
    uncorrectable_d = valid & unc_next;
    gate_err_d      = clear ? 1'b0 : (gate_err_q | (valid & (z != maj3(a, b, c))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_q          <= 1'b0;
      vote_valid_q    <= 1'b0;
      mismatch_q      <= '0;
      uncorrectable_q <= 1'b0;
      gate_err_q      <= 1'b0;
    end else begin
      vote_q          <= vote_d;
      vote_valid_q    <= vote_valid_d;
      mismatch_q      <= mismatch_d;
      uncorrectable_q <= uncorrectable_d;
      gate_err_q      <= gate_err_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_trk
    tmr_channel_tracker #(
      .THRESH(THRESH),
      .CNT_W (CNT_W)
    ) u_trk (
      .clk   (clk),
      .rst   (rst),
      .en    (valid & ~unc_next),
      .mis   (mis_next[i]),
      .clear (clear),
      .faulty(fault[i])
    );
  end

  assign vote          = vote_q;
  assign vote_valid    = vote_valid_q;
  assign mismatch      = mismatch_q;
  assign uncorrectable = uncorrectable_q;
  assign gate_err      = gate_err_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_tmr_fault_monitor;
  localparam int THRESH = 4;
  localparam int CNT_W  = 3;

  logic       clk;
  logic       rst, valid, a, b, c, z, clear;
  logic       vote, vote_valid, uncorrectable, gate_err;
  logic [2:0] mismatch, fault;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  bit       m_vote, m_vv, m_unc, m_gerr;
  bit [2:0] m_mis;
  bit       m_fault[3];
  int       m_cnt[3];

  tmr_fault_monitor #(.THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .a            (a),
    .b            (b),
    .c            (c),
    .z            (z),
    .clear        (clear),
    .vote         (vote),
    .vote_valid   (vote_valid),
    .mismatch     (mismatch),
    .fault        (fault),
    .uncorrectable(uncorrectable),
    .gate_err     (gate_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit maj_ref(bit x, bit y, bit w);
    return (int'(x) + int'(y) + int'(w)) >= 2;
  endfunction

  task automatic check(string tag, logic [2:0] obs, logic [2:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int chv[3];
    int hv[$];
    bit vn, un, gbad;
    bit [2:0] mis;
    if (rst) begin
      m_vote = 0; m_vv = 0; m_unc = 0; m_gerr = 0; m_mis = '0;
      for (int i = 0; i < 3; i++) begin m_fault[i] = 0; m_cnt[i] = 0; end
      return;
    end
    chv = '{int'(a), int'(b), int'(c)};
    for (int i = 0; i < 3; i++)
      if (clear || !m_fault[i]) hv.push_back(chv[i]);
    un = 0;
    vn = m_vote;
    if (hv.size() == 3) vn = z;
    else if (hv.size() == 2) begin
      if (hv[0] == hv[1]) vn = hv[0] != 0;
      else un = 1;
    end else if (hv.size() == 1) vn = hv[0] != 0;
    else un = 1;
    mis = '0;
    for (int i = 0; i < 3; i++)
      mis[i] = !un && (clear || !m_fault[i]) && (chv[i] != int'(vn));
    gbad = (z != maj_ref(a, b, c));
    if (valid) begin
      m_vote = vn; m_vv = 1; m_mis = mis; m_unc = un;
    end else begin
      m_vv = 0; m_unc = 0;
    end
    if (clear) begin
      m_gerr = 0;
      for (int i = 0; i < 3; i++) begin m_fault[i] = 0; m_cnt[i] = 0; end
    end else begin
      if (valid && gbad) m_gerr = 1;
      if (valid && !un)
        for (int i = 0; i < 3; i++) begin
          if (m_fault[i]) continue;
          if (mis[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] >= THRESH) m_fault[i] = 1;
          end else m_cnt[i] = 0;
        end
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".vote"},     {2'b00, vote},          {2'b00, m_vote});
    check({tag, ".vv"},       {2'b00, vote_valid},    {2'b00, m_vv});
    check({tag, ".mismatch"}, mismatch,               m_mis);
    check({tag, ".fault"},    fault,                  {m_fault[2], m_fault[1], m_fault[0]});
    check({tag, ".unc"},      {2'b00, uncorrectable}, {2'b00, m_unc});
    check({tag, ".gate_err"}, {2'b00, gate_err},      {2'b00, m_gerr});
  endtask

  task automatic step(string tag, bit r, bit v, bit x, bit y, bit w, bit zz, bit cl);
    rst = r; valid = v; a = x; b = y; c = w; z = zz; clear = cl;
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, ".vote0"},  {2'b00, vote},          3'b000);
    check({tag, ".vv0"},    {2'b00, vote_valid},    3'b000);
    check({tag, ".mis0"},   mismatch,               3'b000);
    check({tag, ".fault0"}, fault,                  3'b000);
    check({tag, ".unc0"},   {2'b00, uncorrectable}, 3'b000);
    check({tag, ".gerr0"},  {2'b00, gate_err},      3'b000);
  endtask

  initial begin
    logic [2:0] sweep_mis[8];
    logic [2:0] abc;
    int         bad;
    bit         t, v, cl, r, zz;
    bit         chs[3];

    sweep_mis = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000};
    rst = 1; valid = 0; a = 0; b = 0; c = 0; z = 0; clear = 0;

    // Reset held for two cycles with random inputs, then released idle
    repeat (2) step("reset", 1, 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
    check_all_zero("reset");
    step("release", 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    check_all_zero("release");

    // Clean sweep with a correct gate
    for (int k = 0; k < 8; k++) begin
      abc = 3'(k);
      step("sweep", 0, 1, abc[2], abc[1], abc[0], maj_ref(abc[2], abc[1], abc[0]), 0);
      check("sweep.vote_exp", {2'b00, vote}, {2'b00, maj_ref(abc[2], abc[1], abc[0])});
      check("sweep.mis_exp", mismatch, sweep_mis[k]);
    end

    // Interrupted suspect on channel c, with a valid gap
    repeat (3) step("intr", 0, 1, 0, 0, 1, 0, 0);
    step("intr_agree", 0, 1, 0, 0, 0, 0, 0);
    repeat (2) step("intr", 0, 1, 0, 0, 1, 0, 0);
    step("intr_gap", 0, 0, 0, 0, 1, 0, 0);
    check("intr_gap.mis_hold", mismatch, 3'b100);
    check("intr_gap.vv", {2'b00, vote_valid}, 3'b000);
    step("intr", 0, 1, 0, 0, 1, 0, 0);
    check("intr.fault_exp", fault, 3'b000);

    // Gate miscomputes maj(1,1,0)
    step("gate", 0, 1, 1, 1, 0, 0, 0);
    check("gate.gerr_exp", {2'b00, gate_err}, 3'b001);
    check("gate.vote_exp", {2'b00, vote}, 3'b000);
    step("gate_sticky", 0, 1, 0, 0, 0, 0, 0);
    check("gate_sticky.gerr_exp", {2'b00, gate_err}, 3'b001);

    // Channel c stuck high
    for (int k = 0; k < 4; k++) begin
      step("stuck", 0, 1, 0, 0, 1, 0, 0);
      check("stuck.mis_exp", mismatch, 3'b100);
      check("stuck.fault_exp", fault, (k == 3) ? 3'b100 : 3'b000);
    end
    step("no_majority", 0, 1, 1, 0, 1, 1, 0);
    check("no_majority.unc_exp", {2'b00, uncorrectable}, 3'b001);
    check("no_majority.vote_exp", {2'b00, vote}, 3'b000);
    step("idle", 0, 0, 1, 0, 1, 1, 0);
    check("idle.unc_exp", {2'b00, uncorrectable}, 3'b000);

    // Clear together with a sample, then re-fault from zeroed counters
    step("clear", 0, 1, 0, 1, 1, 1, 1);
    check("clear.fault_exp", fault, 3'b000);
    check("clear.gerr_exp", {2'b00, gate_err}, 3'b000);
    check("clear.vote_exp", {2'b00, vote}, 3'b001);
    check("clear.vv_exp", {2'b00, vote_valid}, 3'b001);
    for (int k = 0; k < 4; k++) begin
      step("refault", 0, 1, 0, 0, 1, 0, 0);
      check("refault.fault_exp", fault, (k == 3) ? 3'b100 : 3'b000);
    end

    // Randomized traffic with a drifting misbehaving channel
    bad = 3;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) bad = int'($urandom_range(0, 3));
      t = 1'($urandom);
      for (int j = 0; j < 3; j++) chs[j] = t;
      if (bad < 3 && $urandom_range(0, 9) < 7) chs[bad] = ~t;
      if ($urandom_range(0, 9) == 0) chs[$urandom_range(0, 2)] ^= 1'b1;
      zz = maj_ref(chs[0], chs[1], chs[2]);
      if ($urandom_range(0, 19) == 0) zz = ~zz;
      v  = $urandom_range(0, 9) < 8;
      cl = $urandom_range(0, 49) == 0;
      r  = $urandom_range(0, 149) == 0;
      step("rand", r, v, chs[0], chs[1], chs[2], zz, cl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
